// File: rtl/ara_ar_scheduler.sv
// ============================================================================
// ara_ar_scheduler: shares one AR channel between CVA6 and Ara (rev 1.0)
// ============================================================================
`default_nettype none

module ara_ar_scheduler #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned MaxTxns   = 4,
  parameter int unsigned MaxWait   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cva6_ar_valid_i,
  output logic                           cva6_ar_ready_o,
  input  logic [AddrWidth-1:0]           cva6_ar_addr_i,
  input  logic [IdWidth-1:0]             cva6_ar_id_i,
  input  logic [7:0]                     cva6_ar_len_i,
  input  logic                           ara_ar_valid_i,
  output logic                           ara_ar_ready_o,
  input  logic [AddrWidth-1:0]           ara_ar_addr_i,
  input  logic [IdWidth-1:0]             ara_ar_id_i,
  input  logic [7:0]                     ara_ar_len_i,
  output logic                           mst_ar_valid_o,
  input  logic                           mst_ar_ready_i,
  output logic [AddrWidth-1:0]           mst_ar_addr_o,
  output logic [IdWidth:0]               mst_ar_id_o,
  output logic [7:0]                     mst_ar_len_o,
  input  logic                           mst_r_valid_i,
  input  logic                           mst_r_ready_i,
  input  logic                           mst_r_last_i,
  input  logic [IdWidth:0]               mst_r_id_i,
  output logic [$clog2(MaxTxns+1)-1:0]   cva6_outstanding_o,
  output logic [$clog2(MaxTxns+1)-1:0]   ara_outstanding_o,
  output logic                           err_o
);

  localparam int unsigned CntW  = $clog2(MaxTxns + 1);
  localparam int unsigned WaitW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(MaxTxns);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

  logic                 slot_valid_q, slot_valid_d;
  logic [AddrWidth-1:0] slot_addr_q, slot_addr_d;
  logic [IdWidth:0]     slot_id_q, slot_id_d;
  logic [7:0]           slot_len_q, slot_len_d;
  logic [CntW-1:0]      cva6_cnt_q, cva6_cnt_d;
  logic [CntW-1:0]      ara_cnt_q, ara_cnt_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 err_q, err_d;

  logic slot_load;
  logic cva6_elig, ara_elig, ara_force;
  logic cva6_win, ara_win, cva6_gnt, ara_gnt;
  logic r_fire, cva6_ret, ara_ret;
  logic unused_r_id;

  assign slot_load = ~slot_valid_q | mst_ar_ready_i;
  assign cva6_elig = cva6_ar_valid_i & (cva6_cnt_q < CntMax);
  assign ara_elig  = ara_ar_valid_i & (ara_cnt_q < CntMax);
  assign ara_force = ara_elig & (wait_q == WaitMax);

  // Arbitration uses only eligibility and the wait counter, never the other ready.
  assign cva6_win = cva6_elig & ~ara_force;
  assign ara_win  = ara_elig & ~cva6_win;
  assign cva6_gnt = slot_load & cva6_win;
  assign ara_gnt  = slot_load & ara_win;

  assign cva6_ar_ready_o = cva6_gnt;
  assign ara_ar_ready_o  = ara_gnt;

  assign r_fire   = mst_r_valid_i & mst_r_ready_i & mst_r_last_i;
  assign cva6_ret = r_fire & ~mst_r_id_i[IdWidth];
  assign ara_ret  = r_fire & mst_r_id_i[IdWidth];
  assign unused_r_id = ^mst_r_id_i[IdWidth-1:0];

  function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_id_d    = slot_id_q;
    slot_len_d   = slot_len_q;
    if (slot_load) begin
      slot_valid_d = cva6_gnt | ara_gnt;
      if (cva6_gnt) begin
        slot_addr_d = cva6_ar_addr_i;
        slot_id_d   = {1'b0, cva6_ar_id_i};
        slot_len_d  = cva6_ar_len_i;
      end else if (ara_gnt) begin
        slot_addr_d = ara_ar_addr_i;
        slot_id_d   = {1'b1, ara_ar_id_i};
        slot_len_d  = ara_ar_len_i;
      end
    end
  end

  always_comb begin
    cva6_cnt_d = next_cnt(cva6_cnt_q, cva6_gnt, cva6_ret);
    ara_cnt_d  = next_cnt(ara_cnt_q, ara_gnt, ara_ret);
    err_d      = err_q | (cva6_ret & (cva6_cnt_q == '0)) | (ara_ret & (ara_cnt_q == '0));
  end

  // Only counts losses to an actual CVA6 load; a stalled slot freezes the count.
  always_comb begin
    wait_d = wait_q;
    if (!ara_elig) begin
      wait_d = '0;
    end else if (slot_load) begin
      if (ara_gnt) begin
        wait_d = '0;
      end else if (cva6_gnt && (wait_q != WaitMax)) begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_id_q    <= '0;
      slot_len_q   <= '0;
      cva6_cnt_q   <= '0;
      ara_cnt_q    <= '0;
      wait_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_id_q    <= slot_id_d;
      slot_len_q   <= slot_len_d;
      cva6_cnt_q   <= cva6_cnt_d;
      ara_cnt_q    <= ara_cnt_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
    end
  end

  assign mst_ar_valid_o     = slot_valid_q;
  assign mst_ar_addr_o      = slot_addr_q;
  assign mst_ar_id_o        = slot_id_q;
  assign mst_ar_len_o       = slot_len_q;
  assign cva6_outstanding_o = cva6_cnt_q;
  assign ara_outstanding_o  = ara_cnt_q;
  assign err_o              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ara_ar_scheduler.sv
// ============================================================================
// tb_ara_ar_scheduler: directed scoreboard bench for ara_ar_scheduler (rev 1.0)
// ============================================================================
`default_nettype none

module tb_ara_ar_scheduler;

  logic        clk;
  logic        rst;
  logic        cva6_ar_valid_i, cva6_ar_ready_o;
  logic [63:0] cva6_ar_addr_i;
  logic [5:0]  cva6_ar_id_i;
  logic [7:0]  cva6_ar_len_i;
  logic        ara_ar_valid_i, ara_ar_ready_o;
  logic [63:0] ara_ar_addr_i;
  logic [5:0]  ara_ar_id_i;
  logic [7:0]  ara_ar_len_i;
  logic        mst_ar_valid_o, mst_ar_ready_i;
  logic [63:0] mst_ar_addr_o;
  logic [6:0]  mst_ar_id_o;
  logic [7:0]  mst_ar_len_o;
  logic        mst_r_valid_i, mst_r_ready_i, mst_r_last_i;
  logic [6:0]  mst_r_id_i;
  logic [2:0]  cva6_outstanding_o, ara_outstanding_o;
  logic        err_o;

  typedef struct packed {
    logic [63:0] addr;
    logic [6:0]  id;
    logic [7:0]  len;
  } ar_t;

  ar_t sb[$];
  int  checks = 0;
  int  errors = 0;
  logic exp_c, exp_a;
  int  mc, ma, rc, ra;

  ara_ar_scheduler #(
    .AddrWidth(64), .IdWidth(6), .MaxTxns(4), .MaxWait(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cva6_ar_valid_i(cva6_ar_valid_i), .cva6_ar_ready_o(cva6_ar_ready_o),
    .cva6_ar_addr_i(cva6_ar_addr_i), .cva6_ar_id_i(cva6_ar_id_i), .cva6_ar_len_i(cva6_ar_len_i),
    .ara_ar_valid_i(ara_ar_valid_i), .ara_ar_ready_o(ara_ar_ready_o),
    .ara_ar_addr_i(ara_ar_addr_i), .ara_ar_id_i(ara_ar_id_i), .ara_ar_len_i(ara_ar_len_i),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_id_o(mst_ar_id_o), .mst_ar_len_o(mst_ar_len_o),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_i(mst_r_ready_i),
    .mst_r_last_i(mst_r_last_i), .mst_r_id_i(mst_r_id_i),
    .cva6_outstanding_o(cva6_outstanding_o), .ara_outstanding_o(ara_outstanding_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic peek_slot(input string name);
    ar_t e;
    e = sb[0];
    chk({name, "_valid"}, mst_ar_valid_o, 1);
    chk({name, "_addr"}, mst_ar_addr_o, e.addr);
    chk({name, "_id"}, mst_ar_id_o, e.id);
    chk({name, "_len"}, mst_ar_len_o, e.len);
  endtask

  // Compare ready against the directed expectation, pop on an outgoing handshake,
  // push the expected outgoing payload on an input grant.
  task automatic monitor();
    ar_t e;
    chk("cva6_ready", cva6_ar_ready_o, exp_c);
    chk("ara_ready", ara_ar_ready_o, exp_a);
    if (mst_ar_valid_o && mst_ar_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed handshake id %0h expected none", mst_ar_id_o);
      end else begin
        e = sb.pop_front();
        chk("ar_addr", mst_ar_addr_o, e.addr);
        chk("ar_id", mst_ar_id_o, e.id);
        chk("ar_len", mst_ar_len_o, e.len);
      end
    end
    if (exp_c) sb.push_back('{cva6_ar_addr_i, {1'b0, cva6_ar_id_i}, cva6_ar_len_i});
    if (exp_a) sb.push_back('{ara_ar_addr_i, {1'b1, ara_ar_id_i}, ara_ar_len_i});
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic v, input logic [6:0] id);
    mst_r_valid_i = v;
    mst_r_ready_i = v;
    mst_r_last_i  = v;
    mst_r_id_i    = id;
  endtask

  initial begin
    rst = 1'b1;
    cva6_ar_valid_i = 0; cva6_ar_addr_i = '0; cva6_ar_id_i = '0; cva6_ar_len_i = '0;
    ara_ar_valid_i  = 0; ara_ar_addr_i  = '0; ara_ar_id_i  = '0; ara_ar_len_i  = '0;
    mst_ar_ready_i  = 1'b1;
    set_r(0, '0);
    exp_c = 0; exp_a = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mst_valid", mst_ar_valid_o, 0);
    chk("rst_mst_addr", mst_ar_addr_o, 0);
    chk("rst_mst_id", mst_ar_id_o, 0);
    chk("rst_mst_len", mst_ar_len_o, 0);
    chk("rst_cva6_out", cva6_outstanding_o, 0);
    chk("rst_ara_out", ara_outstanding_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    cyc();

    // Single CVA6 read and its retirement
    cva6_ar_valid_i = 1; cva6_ar_addr_i = 64'h8000_0000; cva6_ar_id_i = 6'd3; cva6_ar_len_i = 8'd0;
    exp_c = 1;
    cyc();
    cva6_ar_valid_i = 0; exp_c = 0;
    chk("t1_mst_valid", mst_ar_valid_o, 1);
    chk("t1_cva6_out", cva6_outstanding_o, 1);
    cyc();
    chk("t1_cva6_out_hold", cva6_outstanding_o, 1);
    set_r(1, 7'h03);
    cyc();
    set_r(0, '0);
    chk("t1_cva6_out_ret", cva6_outstanding_o, 0);

    // Fixed priority with anti-starvation: 16 CVA6 grants then one Ara grant
    cva6_ar_valid_i = 1; cva6_ar_addr_i = 64'h1000; cva6_ar_id_i = 6'd5; cva6_ar_len_i = 8'd7;
    ara_ar_valid_i  = 1; ara_ar_addr_i  = 64'h2000; ara_ar_id_i  = 6'd9; ara_ar_len_i  = 8'd3;
    mc = 0; ma = 0;
    for (int i = 0; i < 51; i++) begin
      exp_a = ((i % 17) == 16);
      exp_c = !exp_a;
      rc = 0; ra = 0;
      if (mc > 0) begin
        set_r(1, 7'h05); rc = 1;
      end else if (ma > 0) begin
        set_r(1, 7'h49); ra = 1;
      end else begin
        set_r(0, '0);
      end
      cyc();
      mc = mc + int'(exp_c) - rc;
      ma = ma + int'(exp_a) - ra;
    end
    cva6_ar_valid_i = 0; ara_ar_valid_i = 0; exp_c = 0; exp_a = 0;
    for (int k = 0; k < 8 && (mc > 0 || ma > 0); k++) begin
      if (mc > 0) begin
        set_r(1, 7'h05); mc--;
      end else begin
        set_r(1, 7'h49); ma--;
      end
      cyc();
    end
    set_r(0, '0);
    cyc();
    chk("t2_cva6_out", cva6_outstanding_o, 0);
    chk("t2_ara_out", ara_outstanding_o, 0);
    chk("t2_sb_empty", sb.size(), 0);

    // Ara outstanding cap
    ara_ar_valid_i = 1; ara_ar_addr_i = 64'h4000; ara_ar_len_i = 8'd15;
    for (int k = 0; k < 4; k++) begin
      ara_ar_id_i = 6'(k);
      exp_a = 1;
      cyc();
    end
    ara_ar_id_i = 6'd4; exp_a = 0;
    cyc();
    cyc();
    chk("t3_ara_out_cap", ara_outstanding_o, 4);
    set_r(1, 7'h40);
    cyc();
    set_r(0, '0);
    exp_a = 1;
    cyc();
    ara_ar_valid_i = 0; exp_a = 0;
    chk("t3_ara_out_refill", ara_outstanding_o, 4);
    for (int k = 0; k < 4; k++) begin
      set_r(1, 7'h40);
      cyc();
    end
    set_r(0, '0);
    chk("t3_ara_out_ret", ara_outstanding_o, 0);
    chk("t3_err", err_o, 0);

    // Backpressure: slot held, readies low, wait counter frozen
    mst_ar_ready_i = 0;
    cva6_ar_valid_i = 1; cva6_ar_addr_i = 64'hA0; cva6_ar_id_i = 6'd1; cva6_ar_len_i = 8'd2;
    ara_ar_valid_i  = 1; ara_ar_addr_i  = 64'hB0; ara_ar_id_i  = 6'd2; ara_ar_len_i  = 8'd4;
    exp_c = 1; exp_a = 0;
    cyc();
    exp_c = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      peek_slot("t4_stall");
    end
    chk("t4_wait_hold", dut.wait_q, 1);
    mst_ar_ready_i = 1; exp_c = 1;
    cyc();
    chk("t4_wait_inc", dut.wait_q, 2);
    cva6_ar_valid_i = 0; ara_ar_valid_i = 0; exp_c = 0;
    cyc();
    chk("t4_cva6_out", cva6_outstanding_o, 2);
    set_r(1, 7'h01);
    cyc();
    cyc();
    set_r(0, '0);
    chk("t4_cva6_out_ret", cva6_outstanding_o, 0);

    // Retirement at zero sets sticky error; reset clears everything
    set_r(1, 7'h03);
    cyc();
    set_r(0, '0);
    chk("t5_err_set", err_o, 1);
    chk("t5_cva6_out_zero", cva6_outstanding_o, 0);
    cyc();
    chk("t5_err_sticky", err_o, 1);
    mst_ar_ready_i = 0;
    cva6_ar_valid_i = 1; cva6_ar_addr_i = 64'hC0; cva6_ar_id_i = 6'd7; exp_c = 1;
    cyc();
    cva6_ar_valid_i = 0; exp_c = 0;
    chk("t5_pre_rst_valid", mst_ar_valid_o, 1);
    chk("t5_pre_rst_out", cva6_outstanding_o, 1);
    rst = 1;
    sb.delete();
    cyc();
    rst = 0;
    chk("t5_rst_err", err_o, 0);
    chk("t5_rst_valid", mst_ar_valid_o, 0);
    chk("t5_rst_cva6_out", cva6_outstanding_o, 0);
    chk("t5_rst_ara_out", ara_outstanding_o, 0);

    // Same-cycle grant and retirement on CVA6 nets to zero
    mst_ar_ready_i = 1;
    cva6_ar_valid_i = 1; cva6_ar_addr_i = 64'hD0; cva6_ar_id_i = 6'd4; cva6_ar_len_i = 8'd1;
    exp_c = 1;
    cyc();
    cyc();
    chk("t6_cva6_out_2", cva6_outstanding_o, 2);
    set_r(1, 7'h04);
    cyc();
    set_r(0, '0);
    chk("t6_cva6_out_net0", cva6_outstanding_o, 2);
    cva6_ar_valid_i = 0; exp_c = 0;
    cyc();
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_err", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ara_ar_scheduler.md
Name: ara_ar_scheduler

Overview:
Read-address scheduler that shares the single system AR channel between the CVA6 scalar core (narrow, latency-critical) and Ara's vector load unit (wide, bandwidth-heavy).
- Arbitration is fixed priority to CVA6, with an anti-starvation guard for Ara.
- Each requester has a cap on outstanding read transactions.
- A port tag is prepended to the outgoing ID. R-channel completions are snooped to retire outstanding reads.
- Sits in front of the system AXI mux, on the AR path only.

Parameters:
AddrWidth, 64, AR address width
IdWidth, 6, per-requester AR/R ID width
MaxTxns, 4, max outstanding reads per requester (>=1)
MaxWait, 16, cycles an eligible Ara request may lose before it is forced to win (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cva6_ar_valid_i  in  1  CVA6 AR valid
cva6_ar_ready_o  out  1  CVA6 AR ready
cva6_ar_addr_i  in  AddrWidth  CVA6 AR address
cva6_ar_id_i  in  IdWidth  CVA6 AR ID
cva6_ar_len_i  in  8  CVA6 AR burst length
ara_ar_valid_i  in  1  Ara AR valid
ara_ar_ready_o  out  1  Ara AR ready
ara_ar_addr_i  in  AddrWidth  Ara AR address
ara_ar_id_i  in  IdWidth  Ara AR ID
ara_ar_len_i  in  8  Ara AR burst length
mst_ar_valid_o  out  1  system AR valid
mst_ar_ready_i  in  1  system AR ready
mst_ar_addr_o  out  AddrWidth  system AR address
mst_ar_id_o  out  IdWidth+1  {port tag, ID}; tag 0=CVA6, 1=Ara
mst_ar_len_o  out  8  system AR burst length
mst_r_valid_i  in  1  snooped R valid
mst_r_ready_i  in  1  snooped R ready
mst_r_last_i  in  1  snooped R last
mst_r_id_i  in  IdWidth+1  snooped R ID; MSB is the port tag
cva6_outstanding_o  out  $clog2(MaxTxns+1)  CVA6 outstanding-read count
ara_outstanding_o  out  $clog2(MaxTxns+1)  Ara outstanding-read count
err_o  out  1  sticky: retirement seen for a port whose count is zero

Behaviour:
- Reset (rst_i high at a clk_i edge) clears the output slot, both counters, the wait counter and err_o.
  - Reset values: mst_ar_valid_o=0, mst_ar_addr_o/id_o/len_o=0, both ready_o=0, outstanding_o=0, err_o=0.
  - Reset mid-transfer drops the slot contents. R beats arriving after reset may set err_o; this is intended.
- Output slot: a single registered entry.
  - Load condition: the slot loads when it is empty, or when mst_ar_valid_o & mst_ar_ready_i in the same cycle. Back-to-back grants are therefore possible.
  - Stability: while mst_ar_valid_o=1 and mst_ar_ready_i=0, all mst_ar_* outputs are held stable.
  - Timing: input handshake at cycle N gives mst_ar_valid_o=1 at cycle N+1. Sustained throughput is 1 AR per cycle.
- Eligibility: a port is eligible when its valid_i=1 and its outstanding count < MaxTxns.
- Grant rules:
  - A port's ready_o is high only in a cycle where the slot loads and that port wins. At most one ready_o is high per cycle.
  - ready_o is combinational from valid_i, the counters and mst_ar_ready_i. It never depends on the other port's ready_o.
  - Default: CVA6 wins if eligible, else Ara wins if eligible.
  - Override: if the wait counter == MaxWait and Ara is eligible, Ara wins over CVA6.
- Wait counter, width $clog2(MaxWait+1):
  - Increments by 1 (saturating at MaxWait) in each cycle Ara is eligible and not granted while the slot loads a CVA6 request.
  - Clears on an Ara grant, or whenever Ara is not eligible.
  - Holds when the slot cannot load.
- Outstanding counters:
  - +1 to the granted port on grant.
  - -1 to port mst_r_id_i[IdWidth] on mst_r_valid_i & mst_r_ready_i & mst_r_last_i.
  - Simultaneous +1/-1 on the same port gives a net 0.
  - Decrement at 0: counter stays 0 and err_o is set; err_o clears only on reset.
  - Increment at MaxTxns cannot occur because eligibility blocks it.
- Payload mapping: mst_ar_id_o = {tag, id_i}. Address and len pass unchanged.

Test Plan:
- Single CVA6 AR (addr 0x8000_0000, id 3, len 0), mst_ar_ready_i=1 -> cva6_ar_ready_o=1 at cycle 0; mst_ar_valid_o=1, mst_ar_id_o=0x03, addr 0x8000_0000 at cycle 1; cva6_outstanding_o=1 until an R last with id 0x03 brings it back to 0.
- Both ports valid continuously, MaxWait=16, no R returns, MaxTxns=64 -> CVA6 wins 16 consecutive grants, Ara wins the 17th, and the pattern repeats.
- Ara issues 4 ARs with R never returned, MaxTxns=4 -> ara_ar_ready_o stays 0 on the 5th request and ara_outstanding_o=4. One Ara R last (id MSB=1) -> the 5th request is granted the next cycle.
- mst_ar_ready_i held 0 for 5 cycles with the slot full -> mst_ar_* outputs are unchanged, both ready_o=0, and the wait counter holds.
- R last with id MSB=0 while cva6_outstanding_o=0 -> err_o=1 sticky, counter stays 0. rst_i pulsed for 1 cycle -> err_o=0, all counters 0, mst_ar_valid_o=0.
- Same-cycle CVA6 grant and CVA6 R last at count 2 -> count remains 2.
